// File: rtl/regfile_mp_sb_pkg.sv
// Shared sizing constants for the multi-port register file and its scoreboard.
package regfile_mp_sb_pkg;

   localparam int DEF_XLEN   = 64;
   localparam int DEF_NREG   = 32;
   localparam int DEF_REG_AW = $clog2(DEF_NREG);
   localparam int ZERO_REG   = 0;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending-write tracking: set on issue, clear on writeback, flush/reset clear all.
module regfile_mp_sb_scoreboard
   import regfile_mp_sb_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rs_addr_i,
   output logic [NRD-1:0]    rs_busy_o,
   input  logic [NWR-1:0]    wr_en_i,
   input  logic [NWR*AW-1:0] wr_addr_i,
   input  logic              iss_en_i,
   input  logic [AW-1:0]     iss_addr_i,
   output logic              iss_stall_o,
   input  logic              flush_i,
   output logic [NREG-1:0]   busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] wr_hit;

   // Registers being written back this cycle; they count as already resolved.
   always_comb begin
      wr_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_i[j]) wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
      end
   end

   // busy_q[0] is held at 0, so port address 0 naturally reports not busy.
   always_comb begin
      rs_busy_o = '0;
      for (int k = 0; k < NRD; k++) begin
         rs_busy_o[k] = busy_q[rs_addr_i[k*AW +: AW]] & ~wr_hit[rs_addr_i[k*AW +: AW]];
      end
   end

   // Issue handshake: iss_en_i is the valid, ~iss_stall_o the ready; the
   // destination is claimed only in a cycle where valid && ready.
   assign iss_stall_o = iss_en_i && (iss_addr_i != AW'(ZERO_REG))
                        && busy_q[iss_addr_i] && !wr_hit[iss_addr_i];

   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (iss_en_i && (iss_addr_i != AW'(ZERO_REG)) && !iss_stall_o)
         busy_d[iss_addr_i] = 1'b1;
      if (flush_i) busy_d = '0;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and pending-write scoreboard.
module regfile_mp_sb
   import regfile_mp_sb_pkg::*;
#(
   parameter  int XLEN = DEF_XLEN,
   parameter  int NREG = DEF_NREG,
   parameter  int NRD  = 2,
   parameter  int NWR  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rs_addr_i,
   output logic [NRD*XLEN-1:0] rs_data_o,
   output logic [NRD-1:0]      rs_busy_o,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   input  logic                iss_en_i,
   input  logic [AW-1:0]       iss_addr_i,
   output logic                iss_stall_o,
   input  logic                flush_i,
   output logic [NREG-1:0]     busy_o
);

   logic [XLEN-1:0] regs_q [NREG];

   // Later ports overwrite earlier ones, giving the highest index priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != AW'(ZERO_REG)))
               regs_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = rs_addr_i[k*AW +: AW];

      always_comb begin
         data = regs_q[addr];
         for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr))
               data = wr_data_i[j*XLEN +: XLEN];
         end
         if (addr == AW'(ZERO_REG)) data = '0;
      end

      assign rs_data_o[k*XLEN +: XLEN] = data;
   end

   regfile_mp_sb_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR),
      .AW   (AW)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .rs_addr_i   (rs_addr_i),
      .rs_busy_o   (rs_busy_o),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .iss_en_i    (iss_en_i),
      .iss_addr_i  (iss_addr_i),
      .iss_stall_o (iss_stall_o),
      .flush_i     (flush_i),
      .busy_o      (busy_o)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, bypass/priority, x0, scoreboard, set/clear, flush/reset.
module tb_regfile_mp_sb;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NRD*AW-1:0]   rs_addr = '0;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic [NWR-1:0]      wr_en = '0;
   logic [NWR*AW-1:0]   wr_addr = '0;
   logic [NWR*XLEN-1:0] wr_data = '0;
   logic                iss_en = 1'b0;
   logic [AW-1:0]       iss_addr = '0;
   logic                iss_stall;
   logic                flush = 1'b0;
   logic [NREG-1:0]     busy;

   logic [XLEN-1:0] rs0_data, rs1_data;
   assign rs0_data = rs_data[XLEN-1:0];
   assign rs1_data = rs_data[2*XLEN-1:XLEN];

   int checks = 0;
   int errors = 0;

   regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk         (clk),
      .rst         (rst),
      .rs_addr_i   (rs_addr),
      .rs_data_o   (rs_data),
      .rs_busy_o   (rs_busy),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .iss_en_i    (iss_en),
      .iss_addr_i  (iss_addr),
      .iss_stall_o (iss_stall),
      .flush_i     (flush),
      .busy_o      (busy)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic next_cycle();
      @(negedge clk);
      wr_en  = '0;
      iss_en = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic drive_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_en[j]               = 1'b1;
      wr_addr[j*AW +: AW]    = a;
      wr_data[j*XLEN +: XLEN] = d;
   endtask

   task automatic drive_rd(input int k, input logic [AW-1:0] a);
      rs_addr[k*AW +: AW] = a;
   endtask

   task automatic drive_iss(input logic [AW-1:0] a);
      iss_en   = 1'b1;
      iss_addr = a;
   endtask

   // Scenarios
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive_rd(0, AW'(i));
         drive_rd(1, AW'(31 - i));
         #1;
         checks++;
         if (rs0_data !== '0 || rs1_data !== '0) begin
            errors++;
            $display("FAIL reset_read x%0d/x%0d: got %h %h expected 0", i, 31 - i, rs0_data, rs1_data);
         end
         checks++;
         if (rs_busy !== 2'b00 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_ports: got rs_busy %b stall %b expected 00 0", rs_busy, iss_stall);
         end
         next_cycle();
      end
      checks++;
      if (busy !== '0) begin
         errors++;
         $display("FAIL reset_busy_vec: got %h expected 0", busy);
      end
   endtask

   task automatic test_bypass();
      drive_wr(0, 5'd5, 64'h11);
      drive_wr(1, 5'd5, 64'h22);
      drive_rd(0, 5'd5);
      drive_rd(1, 5'd0);
      #1;
      checks++;
      if (rs0_data !== 64'h22) begin
         errors++;
         $display("FAIL bypass_priority: got %h expected 22", rs0_data);
      end
      checks++;
      if (rs1_data !== 64'h0) begin
         errors++;
         $display("FAIL bypass_rd_x0: got %h expected 0", rs1_data);
      end
      next_cycle();
      drive_rd(0, 5'd5);
      drive_wr(0, 5'd6, 64'h33);
      drive_wr(1, 5'd8, 64'h44);
      drive_rd(1, 5'd8);
      #1;
      checks++;
      if (rs0_data !== 64'h22) begin
         errors++;
         $display("FAIL stored_priority: got %h expected 22", rs0_data);
      end
      checks++;
      if (rs1_data !== 64'h44) begin
         errors++;
         $display("FAIL bypass_port1: got %h expected 44", rs1_data);
      end
      next_cycle();
      drive_rd(0, 5'd6);
      drive_rd(1, 5'd8);
      #1;
      checks++;
      if (rs0_data !== 64'h33 || rs1_data !== 64'h44) begin
         errors++;
         $display("FAIL stored_two_ports: got %h %h expected 33 44", rs0_data, rs1_data);
      end
      checks++;
      if (busy !== '0) begin
         errors++;
         $display("FAIL write_nonbusy: got busy %h expected 0", busy);
      end
   endtask

   task automatic test_reg0();
      next_cycle();
      drive_wr(0, 5'd0, 64'hFFFF);
      drive_rd(0, 5'd0);
      drive_iss(5'd0);
      #1;
      checks++;
      if (rs0_data !== '0) begin
         errors++;
         $display("FAIL x0_bypass: got %h expected 0", rs0_data);
      end
      checks++;
      if (iss_stall !== 1'b0) begin
         errors++;
         $display("FAIL x0_stall: got %b expected 0", iss_stall);
      end
      next_cycle();
      drive_rd(0, 5'd0);
      #1;
      checks++;
      if (rs0_data !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL x0_after: got data %h busy %h expected 0 0", rs0_data, busy);
      end
   endtask

   task automatic test_scoreboard();
      next_cycle();
      drive_rd(1, 5'd0);
      drive_iss(5'd7);
      #1;
      checks++;
      if (iss_stall !== 1'b0) begin
         errors++;
         $display("FAIL sb_first_issue_stall: got %b expected 0", iss_stall);
      end
      next_cycle();
      drive_rd(0, 5'd7);
      drive_iss(5'd7);
      #1;
      checks++;
      if (busy !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_busy_set: got %h expected 00000080", busy);
      end
      checks++;
      if (rs_busy !== 2'b01) begin
         errors++;
         $display("FAIL sb_rs_busy: got %b expected 01", rs_busy);
      end
      checks++;
      if (iss_stall !== 1'b1) begin
         errors++;
         $display("FAIL sb_second_issue_stall: got %b expected 1", iss_stall);
      end
      next_cycle();
      drive_wr(0, 5'd7, 64'hAB);
      drive_rd(0, 5'd7);
      #1;
      checks++;
      if (busy !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sb_stalled_no_change: got %h expected 00000080", busy);
      end
      checks++;
      if (rs_busy !== 2'b00 || rs0_data !== 64'hAB) begin
         errors++;
         $display("FAIL sb_wb_bypass: got busy %b data %h expected 00 ab", rs_busy, rs0_data);
      end
      next_cycle();
      drive_rd(0, 5'd7);
      #1;
      checks++;
      if (busy !== '0 || rs0_data !== 64'hAB) begin
         errors++;
         $display("FAIL sb_cleared: got busy %h data %h expected 0 ab", busy, rs0_data);
      end
   endtask

   task automatic test_set_clear();
      next_cycle();
      drive_iss(5'd3);
      next_cycle();
      drive_wr(1, 5'd3, 64'h77);
      drive_iss(5'd3);
      drive_rd(0, 5'd3);
      #1;
      checks++;
      if (iss_stall !== 1'b0 || rs_busy[0] !== 1'b0 || rs0_data !== 64'h77) begin
         errors++;
         $display("FAIL setclr_same_cycle: got stall %b busy %b data %h expected 0 0 77",
                  iss_stall, rs_busy[0], rs0_data);
      end
      next_cycle();
      drive_rd(0, 5'd3);
      #1;
      checks++;
      if (busy !== 32'h0000_0008 || rs_busy[0] !== 1'b1 || rs0_data !== 64'h77) begin
         errors++;
         $display("FAIL setclr_after: got busy %h rs_busy %b data %h expected 00000008 1 77",
                  busy, rs_busy[0], rs0_data);
      end
   endtask

   task automatic test_flush_reset();
      next_cycle();
      drive_iss(5'd1);
      next_cycle();
      drive_iss(5'd2);
      next_cycle();
      drive_iss(5'd9);
      next_cycle();
      #1;
      checks++;
      if (busy !== 32'h0000_020E) begin
         errors++;
         $display("FAIL flush_pre: got %h expected 0000020e", busy);
      end
      flush = 1'b1;
      drive_iss(5'd4);
      next_cycle();
      drive_wr(0, 5'd10, 64'h55);
      #1;
      checks++;
      if (busy !== '0) begin
         errors++;
         $display("FAIL flush_clears: got %h expected 0", busy);
      end
      next_cycle();
      drive_iss(5'd12);
      drive_rd(0, 5'd10);
      #1;
      checks++;
      if (rs0_data !== 64'h55) begin
         errors++;
         $display("FAIL pre_reset_x10: got %h expected 55", rs0_data);
      end
      next_cycle();
      #1;
      checks++;
      if (busy !== 32'h0000_1000) begin
         errors++;
         $display("FAIL pre_reset_busy: got %h expected 00001000", busy);
      end
      rst = 1'b1;
      drive_wr(0, 5'd10, 64'h99);
      drive_iss(5'd13);
      next_cycle();
      rst = 1'b0;
      drive_rd(0, 5'd10);
      drive_rd(1, 5'd5);
      #1;
      checks++;
      if (rs0_data !== '0 || rs1_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_op_data: got %h %h expected 0 0", rs0_data, rs1_data);
      end
      checks++;
      if (busy !== '0 || rs_busy !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_op_busy: got %h %b expected 0 00", busy, rs_busy);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_reg0();
      test_scoreboard();
      test_set_clear();
      test_flush_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
